// File: rtl/core_run_ctrl_if.sv
// Host-to-controller program load handshake.
// The host drives valid/data/last; the controller answers with ready.
interface core_run_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;

    modport master (
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/core_run_ctrl.sv
// Load-and-run sequencer: streams a program into instruction memory,
// releases the core, then counts RUN cycles until finish or timeout.
module core_run_ctrl #(
    parameter int          ADDR_W  = 8,
    parameter int          DATA_W  = 32,
    parameter logic [31:0] TIMEOUT = 32'd100000
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    core_run_ctrl_if.slave    load,
    input  logic              finish_flag,
    output logic              core_rst,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    input  logic              ack,
    output logic [31:0]       cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        TOUT
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       cnt_nxt;
    logic              beat;
    logic              beat_last;

    assign load.load_ready = (state == LOAD);
    assign busy    = (state == LOAD) || (state == RUN);
    assign done    = (state == DONE);
    assign timeout = (state == TOUT);

    assign beat      = load.load_valid && (state == LOAD);
    // The top address closes the load so the counter never wraps.
    assign beat_last = load.load_last || (addr == '1);
    assign cnt_nxt   = (cycle_count == '1) ? cycle_count
                                           : cycle_count + 32'd1;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr        <= '0;
            core_rst    <= 1'b1;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            cycle_count <= '0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD;
                        addr        <= '0;
                        cycle_count <= '0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= addr;
                        imem_wdata <= load.load_data;
                        addr       <= addr + ADDR_ONE;
                        if (beat_last) begin
                            state    <= RUN;
                            core_rst <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    cycle_count <= cnt_nxt;
                    // finish in the same cycle as the limit counts as done
                    if (finish_flag) begin
                        state    <= DONE;
                        core_rst <= 1'b1;
                    end else if (cnt_nxt >= TIMEOUT) begin
                        state    <= TOUT;
                        core_rst <= 1'b1;
                    end
                end
                DONE, TOUT: begin
                    if (ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    core_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32: instruction word width.
REQ-003 SHALL have parameter TIMEOUT, default 100000: maximum RUN cycles before abort; legal range 1..2^32-1.
REQ-004 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: start  input  1  host request to begin a load-and-run session.
REQ-007 SHALL have port: load_valid  input  1  host load word valid.
REQ-008 SHALL have port: load_data  input  DATA_W  host instruction word.
REQ-009 SHALL have port: load_last  input  1  marks final word of the program.
REQ-010 SHALL have port: load_ready  output  1  controller accepts load word.
REQ-011 SHALL have port: finish_flag  input  1  core end-of-program indication.
REQ-012 SHALL have port: core_rst  output  1  active-high reset to the core; 1 holds the core in reset.
REQ-013 SHALL have port: imem_we  output  1  instruction-memory write enable.
REQ-014 SHALL have port: imem_addr  output  ADDR_W  instruction-memory write address.
REQ-015 SHALL have port: imem_wdata  output  DATA_W  instruction-memory write data.
REQ-016 SHALL have port: busy  output  1  high in LOAD and RUN.
REQ-017 SHALL have port: done  output  1  high in DONE.
REQ-018 SHALL have port: timeout  output  1  high in TOUT.
REQ-019 SHALL have port: ack  input  1  host acknowledges DONE/TOUT.
REQ-020 SHALL have port: cycle_count  output  32  RUN cycle count of current/last session.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, RUN, DONE, TOUT; all outputs registered except load_ready, busy, done, timeout (decoded from state).
REQ-022 IDLE: core_rst=1, load_ready=0; start=1 -> LOAD, load address counter cleared to 0.
REQ-023 LOAD: load_ready=1; a beat transfers on clock edge where load_valid=1 and load_ready=1.
REQ-024 Each transferred beat k SHALL produce, on the following cycle, imem_we=1, imem_addr=k, imem_wdata=that beat's load_data; imem_we=0 in all other cycles.
REQ-025 Address counter SHALL increment by 1 per beat; a beat at address 2^ADDR_W-1 SHALL be treated as last regardless of load_last (no wrap).
REQ-026 Transfer of the last beat SHALL move LOAD -> RUN at the same edge; load_ready=0 from the next cycle.
REQ-027 On entry to RUN cycle_count SHALL be 0 and core_rst SHALL be 0 throughout RUN (first RUN cycle coincides with the last imem write).
REQ-028 In RUN cycle_count SHALL increment by 1 every cycle, saturating at 2^32-1.
REQ-029 RUN: finish_flag=1 -> DONE at that edge; cycle_count holds value including that cycle.
REQ-030 RUN: cycle_count reaching TIMEOUT with finish_flag=0 -> TOUT; finish_flag=1 in the same cycle SHALL win (DONE).
REQ-031 DONE/TOUT: core_rst=1, cycle_count frozen; ack=1 -> IDLE; cycle_count retained in IDLE until next start.
REQ-032 start SHALL be ignored outside IDLE; ack ignored outside DONE/TOUT; finish_flag ignored outside RUN.
REQ-033 load_data/load_last SHALL be ignored when the handshake does not complete.

Reset
REQ-034 rst=0 SHALL immediately force state IDLE, core_rst=1, imem_we=0, imem_addr=0, imem_wdata=0, cycle_count=0, load_ready=busy=done=timeout=0, from any state including mid-LOAD and mid-RUN.
REQ-035 After rst returns to 1 the block SHALL wait in IDLE for start; no session resumes.

Verification
REQ-036 Load 4 words 0x00000013..0x00000016, last on 4th, valid continuous -> imem_we pulses at addr 0..3 with matching data, core_rst falls the cycle after last beat accepted.
REQ-037 Gapped load_valid (1,0,1,0,1 last) -> exactly 3 writes at addr 0,1,2; no write in gap cycles.
REQ-038 finish_flag asserted on 10th RUN cycle -> done=1, cycle_count=10, core_rst=1; ack -> IDLE, done=0.
REQ-039 TIMEOUT=20, finish_flag never set -> timeout=1, cycle_count=20; with finish_flag on cycle 20 -> done=1 instead.
REQ-040 ADDR_W=2, 5 beats offered without load_last -> 4 writes addr 0..3, RUN entered, 5th beat not accepted.
REQ-041 rst=0 pulsed mid-LOAD and mid-RUN -> all outputs at reset values asynchronously; start afterwards begins fresh load at addr 0.
